pipe_control_unit: RTL and testbench

Pipelined control unit for the KGP-RISC core. It decodes the 32-bit instruction in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers. It also resolves jumps and branches in EX, detects load-use hazards, and generates the stall, flush and bubble signals. It sits between the IF/ID instruction register and the datapath stage registers, and supersedes the single-cycle combinational controller.

---
 rtl/pipe_control_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_pipe_control_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control_unit.sv
// pipe_control_unit
//   Pipelined control unit for the KGP-RISC core. It decodes the ID-stage
//   instruction into a control bundle and carries that bundle through the
//   ID/EX, EX/MEM and MEM/WB registers. It also resolves jumps and branches
//   in EX, detects load-use hazards and generates the stall, flush and
//   bubble signals.
//
// Parameters
//   ALUF_W     ALU function code width (>= 4); codes are zero-extended.
//   HAZARD_EN  1: load-use stall detection; 0: id_stall tied low.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   instr_valid       instr holds a real instruction (0 decodes as bubble)
//   instr             ID-stage instruction word
//   branch_condition  datapath comparison result for ex_brtype (same cycle)
//   ex_alusrc, ex_alufunc, ex_brtype, ex_dest      ID/EX controls
//   mem_dest, mem_readdmem, mem_writedmem          EX/MEM controls
//   wb_dest, wb_regwrite, wb_memtoreg              MEM/WB controls
//   pcsrc, if_flush   take branch/jump target; squash IF/ID at next edge
//   id_stall          hold PC and IF/ID at next edge
//   illegal_instr     ID holds an undefined valid opcode/func
//
// Upstream contract: no valid/ready pair exists here. id_stall=1 means the
// PC and IF/ID must hold their values at the next edge; if_flush=1 means
// IF/ID must be squashed at the next edge. Both may be high together, in
// which case the flush takes priority upstream as it does here.
module pipe_control_unit #(
  parameter int ALUF_W    = 4,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  input  logic              branch_condition,
  output logic              ex_alusrc,
  output logic [ALUF_W-1:0] ex_alufunc,
  output logic [2:0]        ex_brtype,
  output logic [4:0]        ex_dest,
  output logic [4:0]        mem_dest,
  output logic [4:0]        wb_dest,
  output logic              mem_readdmem,
  output logic              mem_writedmem,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic              pcsrc,
  output logic              if_flush,
  output logic              id_stall,
  output logic              illegal_instr
);

  localparam logic [5:0] OP_MOVE = 6'b011010;
  localparam logic [5:0] OP_LD   = 6'b100001;
  localparam logic [5:0] OP_ST   = 6'b100010;
  localparam logic [5:0] OP_BNE  = 6'b110100;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BR   = 3'd1;
  localparam logic [2:0] BR_BLT  = 3'd2;
  localparam logic [2:0] BR_BNE  = 3'd5;

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [5:0] func;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign func   = instr[5:0];

  // Shift-amount field is consumed by the datapath, not by control.
  logic unused_shamt;
  assign unused_shamt = ^instr[10:6];

  // Decoded bundle for the instruction currently in ID.
  logic              d_legal;
  logic              d_alusrc;
  logic [ALUF_W-1:0] d_alufunc;
  logic [2:0]        d_brtype;
  logic [4:0]        d_dest;
  logic              d_readdmem;
  logic              d_writedmem;
  logic              d_regwrite;
  logic              d_memtoreg;
  logic              d_reads_rs;
  logic              d_reads_rt;

  always_comb begin
    d_legal     = 1'b0;
    d_alusrc    = 1'b0;
    d_alufunc   = '0;
    d_brtype    = BR_NONE;
    d_dest      = 5'd0;
    d_readdmem  = 1'b0;
    d_writedmem = 1'b0;
    d_regwrite  = 1'b0;
    d_memtoreg  = 1'b0;
    d_reads_rs  = 1'b0;
    d_reads_rt  = 1'b0;
    if (instr_valid) begin
      case (opcode[5:4])
        2'b00: begin
          // R-type: func 1..10 -> ADD SUB AND OR XOR NOT SLA SLL SRA SRL
          if (func >= 6'd1 && func <= 6'd10) begin
            d_legal    = 1'b1;
            d_alufunc  = ALUF_W'(func - 6'd1);
            d_dest     = rd;
            d_regwrite = 1'b1;
            d_reads_rs = 1'b1;
            d_reads_rt = 1'b1;
          end
        end
        2'b01: begin
          // Immediate ALU ops 010000..011001, plus MOVE which uses ADD.
          if (opcode <= OP_MOVE) begin
            d_legal    = 1'b1;
            d_alusrc   = 1'b1;
            d_alufunc  = (opcode == OP_MOVE) ? '0 : ALUF_W'(opcode[3:0]);
            d_dest     = rt;
            d_regwrite = 1'b1;
            d_reads_rs = 1'b1;
          end
        end
        2'b10: begin
          if (opcode == OP_LD) begin
            d_legal    = 1'b1;
            d_alusrc   = 1'b1;
            d_readdmem = 1'b1;
            d_regwrite = 1'b1;
            d_memtoreg = 1'b1;
            d_dest     = rt;
            d_reads_rs = 1'b1;
          end else if (opcode == OP_ST) begin
            d_legal     = 1'b1;
            d_alusrc    = 1'b1;
            d_writedmem = 1'b1;
            d_reads_rs  = 1'b1;
            d_reads_rt  = 1'b1;
          end
        end
        default: begin
          // 110000 BR .. 110100 BNE map onto brtype 1..5.
          if (opcode <= OP_BNE) begin
            d_legal    = 1'b1;
            d_brtype   = opcode[2:0] + 3'd1;
            d_reads_rs = 1'b1;
            d_reads_rt = (d_brtype != BR_BR);
          end
        end
      endcase
      // Writes to r0 are architecturally discarded.
      if (d_dest == 5'd0) d_regwrite = 1'b0;
    end
  end

  assign illegal_instr = instr_valid & ~d_legal & ~reset;

  // Internal stage controls not exported as ports.
  logic ex_readdmem;
  logic ex_writedmem;
  logic ex_regwrite;
  logic ex_memtoreg;
  logic mem_regwrite;
  logic mem_memtoreg;

  // Branch resolution from the ID/EX register.
  assign pcsrc    = (ex_brtype == BR_BR) |
                    ((ex_brtype >= BR_BLT) & (ex_brtype <= BR_BNE) & branch_condition);
  assign if_flush = pcsrc;

  // A load in EX is the only instruction whose result is not yet forwardable.
  logic load_use;
  assign load_use = ex_readdmem && (ex_dest != 5'd0) &&
                    ((d_reads_rs && (rs == ex_dest)) || (d_reads_rt && (rt == ex_dest)));
  assign id_stall = HAZARD_EN && load_use && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_alusrc     <= 1'b0;
      ex_alufunc    <= '0;
      ex_brtype     <= BR_NONE;
      ex_dest       <= 5'd0;
      ex_readdmem   <= 1'b0;
      ex_writedmem  <= 1'b0;
      ex_regwrite   <= 1'b0;
      ex_memtoreg   <= 1'b0;
      mem_dest      <= 5'd0;
      mem_readdmem  <= 1'b0;
      mem_writedmem <= 1'b0;
      mem_regwrite  <= 1'b0;
      mem_memtoreg  <= 1'b0;
      wb_dest       <= 5'd0;
      wb_regwrite   <= 1'b0;
      wb_memtoreg   <= 1'b0;
    end else begin
      // Flush or stall both insert a bubble; a flushed ID instruction is
      // killed even when it would also have stalled.
      if (pcsrc || id_stall) begin
        ex_alusrc    <= 1'b0;
        ex_alufunc   <= '0;
        ex_brtype    <= BR_NONE;
        ex_dest      <= 5'd0;
        ex_readdmem  <= 1'b0;
        ex_writedmem <= 1'b0;
        ex_regwrite  <= 1'b0;
        ex_memtoreg  <= 1'b0;
      end else begin
        ex_alusrc    <= d_alusrc;
        ex_alufunc   <= d_alufunc;
        ex_brtype    <= d_brtype;
        ex_dest      <= d_dest;
        ex_readdmem  <= d_readdmem;
        ex_writedmem <= d_writedmem;
        ex_regwrite  <= d_regwrite;
        ex_memtoreg  <= d_memtoreg;
      end
      mem_dest      <= ex_dest;
      mem_readdmem  <= ex_readdmem;
      mem_writedmem <= ex_writedmem;
      mem_regwrite  <= ex_regwrite;
      mem_memtoreg  <= ex_memtoreg;
      wb_dest       <= mem_dest;
      wb_regwrite   <= mem_regwrite;
      wb_memtoreg   <= mem_memtoreg;
    end
  end

endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit. Two instances share the same stimulus:
// index 0 has load-use detection enabled, index 1 has it disabled. A
// reference model predicts every output of both each cycle.
module tb_pipe_control_unit;

  localparam int ALUF_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        branch_condition;

  logic              alusrc_o[2];
  logic [ALUF_W-1:0] alufunc_o[2];
  logic [2:0]        brtype_o[2];
  logic [4:0]        exd_o[2];
  logic [4:0]        memd_o[2];
  logic [4:0]        wbd_o[2];
  logic              memrd_o[2];
  logic              memwr_o[2];
  logic              wbrw_o[2];
  logic              wbm2r_o[2];
  logic              pcsrc_o[2];
  logic              flush_o[2];
  logic              stall_o[2];
  logic              ill_o[2];

  pipe_control_unit #(.ALUF_W(ALUF_W), .HAZARD_EN(1'b1)) dut_haz (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .branch_condition(branch_condition),
    .ex_alusrc(alusrc_o[0]), .ex_alufunc(alufunc_o[0]), .ex_brtype(brtype_o[0]),
    .ex_dest(exd_o[0]), .mem_dest(memd_o[0]), .wb_dest(wbd_o[0]),
    .mem_readdmem(memrd_o[0]), .mem_writedmem(memwr_o[0]),
    .wb_regwrite(wbrw_o[0]), .wb_memtoreg(wbm2r_o[0]),
    .pcsrc(pcsrc_o[0]), .if_flush(flush_o[0]), .id_stall(stall_o[0]),
    .illegal_instr(ill_o[0])
  );

  pipe_control_unit #(.ALUF_W(ALUF_W), .HAZARD_EN(1'b0)) dut_nohaz (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .branch_condition(branch_condition),
    .ex_alusrc(alusrc_o[1]), .ex_alufunc(alufunc_o[1]), .ex_brtype(brtype_o[1]),
    .ex_dest(exd_o[1]), .mem_dest(memd_o[1]), .wb_dest(wbd_o[1]),
    .mem_readdmem(memrd_o[1]), .mem_writedmem(memwr_o[1]),
    .wb_regwrite(wbrw_o[1]), .wb_memtoreg(wbm2r_o[1]),
    .pcsrc(pcsrc_o[1]), .if_flush(flush_o[1]), .id_stall(stall_o[1]),
    .illegal_instr(ill_o[1])
  );

  // ---------------- scoreboard / checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit legal;
    bit alusrc;
    int alufunc;
    int brtype;
    int dest;
    bit rdm;
    bit wrm;
    bit rw;
    bit m2r;
    bit rrs;
    bit rrt;
  } bun_t;

  bun_t ex_m[2];
  bun_t mem_m[2];
  bun_t wb_m[2];
  bit   model_ok = 1'b0;

  function automatic bun_t bubble();
    bun_t b;
    b = '{default: 0};
    return b;
  endfunction

  // Instruction table: what each instruction does, by opcode number.
  function automatic bun_t ref_decode(input bit v, input logic [31:0] i);
    bun_t b;
    int op, fn;
    b  = bubble();
    op = int'(i[31:26]);
    fn = int'(i[5:0]);
    if (!v) return b;
    if (op < 16) begin
      if (fn >= 1 && fn <= 10) begin
        b.legal = 1; b.alufunc = fn - 1; b.dest = int'(i[15:11]);
        b.rw = 1; b.rrs = 1; b.rrt = 1;
      end
    end else if (op < 32) begin
      if (op <= 26) begin
        b.legal = 1; b.alusrc = 1; b.alufunc = (op == 26) ? 0 : op - 16;
        b.dest = int'(i[20:16]); b.rw = 1; b.rrs = 1;
      end
    end else if (op == 33) begin
      b.legal = 1; b.alusrc = 1; b.rdm = 1; b.rw = 1; b.m2r = 1;
      b.dest = int'(i[20:16]); b.rrs = 1;
    end else if (op == 34) begin
      b.legal = 1; b.alusrc = 1; b.wrm = 1; b.rrs = 1; b.rrt = 1;
    end else if (op >= 48 && op <= 52) begin
      b.legal = 1; b.brtype = op - 47; b.rrs = 1; b.rrt = (op != 48);
    end
    if (b.dest == 0) b.rw = 0;
    return b;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit v, input logic [31:0] i, input bit bc);
    bun_t d;
    bit   e_pc, e_st, e_ill;
    int   rs_n, rt_n;
    @(negedge clk);
    reset = r; instr_valid = v; instr = i; branch_condition = bc;
    #1;
    cyc++;
    d = ref_decode(v, i);
    rs_n = int'(i[25:21]);
    rt_n = int'(i[20:16]);
    for (int k = 0; k < 2; k++) begin
      e_pc  = (ex_m[k].brtype == 1) || (ex_m[k].brtype >= 2 && ex_m[k].brtype <= 5 && bc);
      e_st  = (k == 0) && !r && ex_m[k].rdm && ex_m[k].dest != 0 &&
              ((d.rrs && rs_n == ex_m[k].dest) || (d.rrt && rt_n == ex_m[k].dest));
      e_ill = v && !d.legal && !r;
      if (model_ok) begin
        check($sformatf("pcsrc[%0d]", k),    32'(pcsrc_o[k]),   32'(e_pc));
        check($sformatf("if_flush[%0d]", k), 32'(flush_o[k]),   32'(e_pc));
        check($sformatf("id_stall[%0d]", k), 32'(stall_o[k]),   32'(e_st));
        check($sformatf("illegal[%0d]", k),  32'(ill_o[k]),     32'(e_ill));
        check($sformatf("ex_alusrc[%0d]", k),  32'(alusrc_o[k]),  32'(ex_m[k].alusrc));
        check($sformatf("ex_alufunc[%0d]", k), 32'(alufunc_o[k]), 32'(ex_m[k].alufunc));
        check($sformatf("ex_brtype[%0d]", k),  32'(brtype_o[k]),  32'(ex_m[k].brtype));
        check($sformatf("ex_dest[%0d]", k),    32'(exd_o[k]),     32'(ex_m[k].dest));
        check($sformatf("mem_dest[%0d]", k),   32'(memd_o[k]),    32'(mem_m[k].dest));
        check($sformatf("mem_rd[%0d]", k),     32'(memrd_o[k]),   32'(mem_m[k].rdm));
        check($sformatf("mem_wr[%0d]", k),     32'(memwr_o[k]),   32'(mem_m[k].wrm));
        check($sformatf("wb_dest[%0d]", k),    32'(wbd_o[k]),     32'(wb_m[k].dest));
        check($sformatf("wb_rw[%0d]", k),      32'(wbrw_o[k]),    32'(wb_m[k].rw));
        check($sformatf("wb_m2r[%0d]", k),     32'(wbm2r_o[k]),   32'(wb_m[k].m2r));
      end
      if (r) begin
        ex_m[k] = bubble(); mem_m[k] = bubble(); wb_m[k] = bubble();
      end else begin
        wb_m[k]  = mem_m[k];
        mem_m[k] = ex_m[k];
        ex_m[k]  = (e_pc || e_st) ? bubble() : d;
      end
    end
    if (r) model_ok = 1'b1;
  endtask

  function automatic logic [31:0] rtype(input int s, input int t, input int d, input int fn);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int s, input int t);
    return {6'(op), 5'(s), 5'(t), 16'h0012};
  endfunction

  function automatic logic [31:0] rand_instr();
    int   k;
    logic [5:0] op, fn;
    logic [4:0] s, t, d;
    k  = int'($urandom_range(0, 9));
    s  = 5'($urandom_range(0, 5));
    t  = 5'($urandom_range(0, 5));
    d  = 5'($urandom_range(0, 5));
    fn = 6'($urandom_range(0, 12));
    case (k)
      0, 1, 2: op = 6'd0;
      3:       op = 6'($urandom_range(16, 27));
      4, 5:    op = 6'($urandom_range(33, 34));
      6, 7:    op = 6'($urandom_range(48, 53));
      8:       op = 6'($urandom_range(0, 63));
      default: return $urandom;
    endcase
    return {op, s, t, d, 5'($urandom_range(0, 31)), fn};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = '0; branch_condition = 1'b0;
    ex_m[0] = bubble(); ex_m[1] = bubble();
    mem_m[0] = bubble(); mem_m[1] = bubble();
    wb_m[0] = bubble(); wb_m[1] = bubble();

    step(1, 0, 0, 0);
    step(1, 1, 32'hFFFF_FFFF, 0);      // instr ignored during reset
    check("rst_illegal", 32'(ill_o[0]), 32'd0);

    // ADD r3,r1,r2 for one cycle
    step(0, 1, rtype(1, 2, 3, 1), 0);
    check("rst_ex_dest", 32'(exd_o[0]), 32'd0);
    step(0, 0, 0, 0);
    check("add_ex_func", 32'(alufunc_o[0]), 32'd0);
    check("add_ex_dest", 32'(exd_o[0]), 32'd3);
    step(0, 0, 0, 0);
    check("add_wb_early", 32'(wbrw_o[0]), 32'd0);
    step(0, 0, 0, 0);
    check("add_wb_rw", 32'(wbrw_o[0]), 32'd1);
    check("add_wb_dest", 32'(wbd_o[0]), 32'd3);

    // LD r4 then SUB r5,r4,r1: one stall, then SUB issues
    step(0, 1, itype(33, 1, 4), 0);
    step(0, 1, rtype(4, 1, 5, 2), 0);
    check("lu_stall", 32'(stall_o[0]), 32'd1);
    check("lu_nostall_dis", 32'(stall_o[1]), 32'd0);
    step(0, 1, rtype(4, 1, 5, 2), 0);
    check("lu_stall_once", 32'(stall_o[0]), 32'd0);
    check("lu_dis_ex_sub", 32'(alufunc_o[1]), 32'd1);
    step(0, 0, 0, 0);
    check("lu_ex_sub", 32'(alufunc_o[0]), 32'd1);
    check("lu_ex_dest", 32'(exd_o[0]), 32'd5);

    // BEQ taken then ADDI r6: ADDI killed
    step(0, 1, itype(51, 1, 2), 0);
    step(0, 1, itype(16, 1, 6), 1);
    check("beq_pcsrc", 32'(pcsrc_o[0]), 32'd1);
    check("beq_flush", 32'(flush_o[0]), 32'd1);
    step(0, 0, 0, 1);
    check("beq_pcsrc_1cyc", 32'(pcsrc_o[0]), 32'd0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("beq_killed_wb", 32'(wbrw_o[0]), 32'd0);

    // BEQ not taken: ADDI completes
    step(0, 1, itype(51, 1, 2), 0);
    step(0, 1, itype(16, 1, 6), 0);
    check("beqnt_pcsrc", 32'(pcsrc_o[0]), 32'd0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("beqnt_wb_rw", 32'(wbrw_o[0]), 32'd1);
    check("beqnt_wb_dest", 32'(wbd_o[0]), 32'd6);

    // BR then LD r4 (flushed) then dependent SUB: no stall
    step(0, 1, itype(48, 7, 0), 0);
    step(0, 1, itype(33, 1, 4), 0);
    check("br_pcsrc", 32'(pcsrc_o[0]), 32'd1);
    step(0, 0, 0, 0);
    step(0, 1, rtype(4, 1, 5, 2), 0);
    check("br_no_stall", 32'(stall_o[0]), 32'd0);

    // Illegal opcode, and ADD to r0
    step(0, 1, itype(63, 1, 2), 0);
    check("ill_flag", 32'(ill_o[0]), 32'd1);
    step(0, 1, rtype(1, 2, 0, 1), 0);
    check("ill_ex_brtype", 32'(brtype_o[0]), 32'd0);
    check("ill_ex_alusrc", 32'(alusrc_o[0]), 32'd0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("r0_wb_rw", 32'(wbrw_o[0]), 32'd0);

    // Reset while LD in MEM
    step(0, 1, itype(33, 1, 4), 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rstld_mem_rd", 32'(memrd_o[0]), 32'd1);
    step(0, 0, 0, 0);
    check("rstld_wb_rw", 32'(wbrw_o[0]), 32'd0);
    check("rstld_wb_m2r", 32'(wbm2r_o[0]), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0,
           rand_instr(), $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
